// File: rtl/mem_stage.sv
// Memory-access stage: waits for data_ok, aligns load data,
// drops responses that belong to flushed instructions.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 171,
  parameter int MS_TO_WS_BUS_WD = 160,
  parameter int DROP_CNT_W      = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       final_ex,
  input  logic                       back_ertn_flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [41:0]                ms_forward,
  output logic                       ms_ertn_flush
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic [31:0]                rdata_buf;
  logic                       buf_valid;
  logic [DROP_CNT_W-1:0]      drop_cnt;

  logic        mem_req;
  logic        ertn;
  logic        ex;
  logic        csr_re;
  logic [1:0]  addr;
  logic        ld_w;
  logic        ld_b;
  logic        ld_bu;
  logic        ld_h;
  logic        ld_hu;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic        unused;

  assign mem_req      = bus_r[170];
  assign ertn         = bus_r[168];
  assign ex           = bus_r[160];
  assign csr_re       = bus_r[159];
  assign addr         = bus_r[79:78];
  assign ld_w         = bus_r[77];
  assign ld_b         = bus_r[76];
  assign ld_bu        = bus_r[75];
  assign ld_h         = bus_r[74];
  assign ld_hu        = bus_r[73];
  assign res_from_mem = bus_r[70];
  assign gr_we        = bus_r[69];
  assign dest         = bus_r[68:64];
  assign result       = bus_r[63:32];
  assign pc           = bus_r[31:0];
  assign unused       = &{1'b0, bus_r[72:71]};

  logic flush;
  logic wait_data;
  logic resp_ok;
  logic ms_ready_go;
  logic ms_leave;
  logic drop_inc;
  logic drop_dec;

  assign flush       = final_ex | back_ertn_flush;
  assign wait_data   = ms_valid & mem_req & ~buf_valid;
  assign resp_ok     = data_sram_data_ok & (drop_cnt == '0);
  assign ms_ready_go = ~wait_data | resp_ok;
  assign ms_allowin  = ~ms_valid | ms_ready_go & ws_allowin;
  assign ms_leave    = ms_valid & ms_ready_go & ws_allowin;
  assign drop_inc    = flush & wait_data & ~resp_ok;
  assign drop_dec    = data_sram_data_ok & (drop_cnt != '0);

  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
  assign ms_ertn_flush  = ms_valid & ertn;

  logic [31:0] mem_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_val;
  logic [31:0] final_result;

  assign mem_data = buf_valid ? rdata_buf : data_sram_rdata;
  assign half_sel = addr[1] ? mem_data[31:16] : mem_data[15:0];

  // Pick the addressed byte lane.
  always_comb begin
    byte_sel = mem_data[7:0];
    case (addr)
      2'd1:    byte_sel = mem_data[15:8];
      2'd2:    byte_sel = mem_data[23:16];
      2'd3:    byte_sel = mem_data[31:24];
      default: byte_sel = mem_data[7:0];
    endcase
  end

  // Extend the selected lane by load type.
  always_comb begin
    ld_val = mem_data;
    unique case (1'b1)
      ld_w:    ld_val = mem_data;
      ld_b:    ld_val = {{24{byte_sel[7]}}, byte_sel};
      ld_bu:   ld_val = {24'd0, byte_sel};
      ld_h:    ld_val = {{16{half_sel[15]}}, half_sel};
      ld_hu:   ld_val = {16'd0, half_sel};
      default: ld_val = mem_data;
    endcase
  end

  assign final_result = (res_from_mem & ~ex) ? ld_val : result;

  assign ms_to_ws_bus = {bus_r[169:80], gr_we, dest, final_result, pc};

  assign ms_forward = {ms_valid & csr_re,
                       ms_valid & (ex | ertn),
                       wait_data & ~resp_ok,
                       final_result,
                       dest,
                       gr_we,
                       ms_valid};

  // Occupancy: flush kills, otherwise refill when allowed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction bus register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_r <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      bus_r <= es_to_ms_bus;
    end
  end

  // Hold a response that arrived while writeback was stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      rdata_buf <= '0;
    end else if (flush || ms_leave) begin
      buf_valid <= 1'b0;
    end else if (resp_ok && wait_data && !ws_allowin) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  // Count responses owed to flushed instructions.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (drop_inc && !drop_dec) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end else if (drop_dec && !drop_inc) begin
      drop_cnt <= drop_cnt - DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic
// scored against a per-instruction expected-result queue.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         final_ex;
  logic         back_ertn_flush;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [170:0] es_to_ms_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [159:0] ms_to_ws_bus;
  logic [41:0]  ms_forward;
  logic         ms_ertn_flush;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .final_ex         (final_ex),
    .back_ertn_flush  (back_ertn_flush),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_forward       (ms_forward),
    .ms_ertn_flush    (ms_ertn_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    int          wait_c;
  } resp_t;

  int           total = 0;
  int           bad = 0;
  resp_t        sram_q[$];
  logic [159:0] exp_q[$];
  logic [170:0] cur_bus;
  logic [159:0] cur_exp;
  logic         cur_mem;
  logic [31:0]  cur_rd;
  int           cur_dly;
  logic         have_pend = 1'b0;
  logic [31:0]  pc_n = 32'h1c00_0000;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Build one instruction and its expected writeback bus.
  task automatic make(input int kind, input logic [1:0] addr,
                      input logic [31:0] rd, input logic [31:0] res,
                      input logic ex, input logic ertn, input int dly);
    logic        ld, st, mem, gwe;
    logic [6:0]  fl;
    logic [31:0] fin, sh;
    logic [4:0]  dest;
    logic [5:0]  ecode;
    logic [13:0] csr_num;
    logic [31:0] wv, wm;
    logic        rdc, esub, csr_re, we;
    int          v;
    ld = (kind >= 1) && (kind <= 5);
    st = (kind >= 6);
    case (kind)
      1:       fl = 7'b1000000;
      2:       fl = 7'b0100000;
      3:       fl = 7'b0010000;
      4:       fl = 7'b0001000;
      5:       fl = 7'b0000100;
      6:       fl = 7'b0000010;
      7:       fl = 7'b0000001;
      default: fl = 7'b0000000;
    endcase
    mem = (ld || st) && !ex;
    gwe = !st;
    fin = res;
    if (ld && !ex) begin
      case (kind)
        1: fin = rd;
        2: begin
          sh = rd >> (8 * addr);
          v = int'(sh & 32'hFF);
          if (v > 127) v -= 256;
          fin = 32'(v);
        end
        3: begin
          sh = rd >> (8 * addr);
          fin = sh & 32'hFF;
        end
        4: begin
          sh = rd >> (16 * addr[1]);
          v = int'(sh & 32'hFFFF);
          if (v > 32767) v -= 65536;
          fin = 32'(v);
        end
        default: begin
          sh = rd >> (16 * addr[1]);
          fin = sh & 32'hFFFF;
        end
      endcase
    end
    dest    = 5'($urandom);
    ecode   = 6'($urandom);
    csr_num = 14'($urandom);
    wv      = $urandom;
    wm      = $urandom;
    rdc     = 1'($urandom);
    esub    = 1'($urandom);
    csr_re  = 1'($urandom);
    we      = 1'($urandom);
    cur_bus = {mem, rdc, ertn, esub, ecode, ex, csr_re, csr_num, wv, wm,
               we, addr, fl, ld, gwe, dest, res, pc_n};
    cur_exp = {rdc, ertn, esub, ecode, ex, csr_re, csr_num, wv, wm,
               we, gwe, dest, fin, pc_n};
    pc_n    = pc_n + 32'd4;
    cur_mem = mem;
    cur_rd  = rd;
    cur_dly = dly;
    es_to_ms_bus = cur_bus;
  endtask

  // One clock: called and returns at the falling edge.
  task automatic tick();
    logic  acc, fl;
    resp_t h;
    #4;
    acc = es_to_ms_valid && ms_allowin;
    fl  = final_ex || back_ertn_flush;
    @(posedge clk);
    #1;
    if (fl && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(cur_exp);
      if (cur_mem) sram_q.push_back('{cur_rd, cur_dly});
      es_to_ms_valid = 1'b0;
      have_pend = 1'b0;
    end
    final_ex = 1'b0;
    back_ertn_flush = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = $urandom;
    if (sram_q.size() > 0) begin
      h = sram_q[0];
      if (h.wait_c == 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata = h.rd;
        void'(sram_q.pop_front());
      end else begin
        h.wait_c--;
        sram_q[0] = h;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_out(input string nm);
    int n = 0;
    while (!(ms_to_ws_valid && ws_allowin) && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL %s: timeout waiting for ms_to_ws_valid", nm);
    end
  endtask

  // Writeback-side monitor: score every instruction handed over.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (resetn && ms_to_ws_valid && ws_allowin) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wb_bus: got %h want none", ms_to_ws_bus);
        end else begin
          logic [159:0] e;
          e = exp_q.pop_front();
          if (ms_to_ws_bus !== e) begin
            bad++;
            $display("FAIL wb_bus: got %h want %h", ms_to_ws_bus, e);
          end
        end
      end
    end
  end

  initial begin
    logic flush;
    resetn = 1'b0;
    final_ex = 1'b0;
    back_ertn_flush = 1'b0;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_wsvalid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_ertn", 32'(ms_ertn_flush), 32'd0);
    chk("rst_fwd_lo", ms_forward[31:0], 32'd0);
    chk("rst_fwd_hi", 32'(ms_forward[41:32]), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    make(2, 2'd3, 32'h80AA55CC, 32'h0, 1'b0, 1'b0, 0);
    es_to_ms_valid = 1'b1;
    tick();
    chk("ldb_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("ldb_result", ms_to_ws_bus[63:32], 32'hFFFFFF80);
    chk("ldb_fwd_res", ms_forward[38:7], 32'hFFFFFF80);
    tick();

    make(5, 2'd2, 32'h8001FFFF, 32'h0, 1'b0, 1'b0, 0);
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    tick();
    chk("ldhu_pend0", 32'(ms_forward[39]), 32'd0);
    tick();
    chk("ldhu_buf", 32'(dut.buf_valid), 32'd1);
    chk("ldhu_pend1", 32'(ms_forward[39]), 32'd0);
    chk("ldhu_allowin", 32'(ms_allowin), 32'd0);
    tick();
    tick();
    ws_allowin = 1'b1;
    chk("ldhu_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("ldhu_result", ms_to_ws_bus[63:32], 32'h00008001);
    tick();

    make(1, 2'd0, 32'h0000DEAD, 32'h0, 1'b0, 1'b0, 3);
    es_to_ms_valid = 1'b1;
    tick();
    chk("drop_pend", 32'(ms_forward[39]), 32'd1);
    final_ex = 1'b1;
    chk("flush_novalid", 32'(ms_to_ws_valid), 32'd0);
    tick();
    chk("drop_cnt1", 32'(dut.drop_cnt), 32'd1);
    chk("flush_gone", 32'(ms_forward[0]), 32'd0);
    make(1, 2'd0, 32'h00001234, 32'h0, 1'b0, 1'b0, 0);
    es_to_ms_valid = 1'b1;
    tick();
    wait_out("drop_wait");
    chk("drop_result", ms_to_ws_bus[63:32], 32'h00001234);
    tick();
    chk("drop_cnt0", 32'(dut.drop_cnt), 32'd0);

    make(1, 2'd0, 32'hCAFE0001, 32'h0, 1'b0, 1'b0, 0);
    es_to_ms_valid = 1'b1;
    tick();
    back_ertn_flush = 1'b1;
    tick();
    chk("same_cyc_cnt", 32'(dut.drop_cnt), 32'd0);
    make(1, 2'd0, 32'h5555AAAA, 32'h0, 1'b0, 1'b0, 1);
    es_to_ms_valid = 1'b1;
    tick();
    wait_out("same_cyc_wait");
    chk("same_cyc_res", ms_to_ws_bus[63:32], 32'h5555AAAA);
    tick();

    make(8, 2'd0, 32'h0, 32'h1c00BEEF, 1'b0, 1'b0, 3);
    es_to_ms_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("st_readygo", 32'(dut.ms_ready_go), 32'd0);
      chk("st_allowin", 32'(ms_allowin), 32'd0);
      tick();
    end
    chk("st_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("st_grwe", 32'(ms_to_ws_bus[69]), 32'd0);
    tick();

    make(0, 2'd0, 32'h0, 32'h0000_0077, 1'b0, 1'b1, 0);
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    tick();
    chk("ertn_flush", 32'(ms_ertn_flush), 32'd1);
    chk("ertn_fwd40", 32'(ms_forward[40]), 32'd1);
    ws_allowin = 1'b1;
    tick();
    make(2, 2'd3, 32'h0, 32'h1c001003, 1'b1, 1'b0, 0);
    es_to_ms_valid = 1'b1;
    tick();
    chk("ale_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("ale_result", ms_to_ws_bus[63:32], 32'h1c001003);
    tick();

    make(1, 2'd0, 32'h0BAD0BAD, 32'h0, 1'b0, 1'b0, 3);
    es_to_ms_valid = 1'b1;
    tick();
    final_ex = 1'b1;
    tick();
    chk("rst_pre_cnt", 32'(dut.drop_cnt), 32'd1);
    resetn = 1'b0;
    sram_q.delete();
    exp_q.delete();
    tick();
    chk("rst_mid_cnt", 32'(dut.drop_cnt), 32'd0);
    resetn = 1'b1;
    tick();

    for (int it = 0; it < 3000; it++) begin
      if (!have_pend && $urandom_range(0, 2) != 0) begin
        make(int'($urandom_range(0, 8)), 2'($urandom), $urandom,
             $urandom, 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 19) == 0),
             int'($urandom_range(0, 3)));
        have_pend = 1'b1;
      end
      flush = ($urandom_range(0, 19) == 0);
      if (flush) begin
        if ($urandom_range(0, 1) == 0) final_ex = 1'b1;
        else back_ertn_flush = 1'b1;
      end
      ws_allowin = ($urandom_range(0, 3) != 0);
      es_to_ms_valid = have_pend && !flush &&
                       !(cur_mem && sram_q.size() >= 2);
      tick();
    end

    es_to_ms_valid = 1'b0;
    have_pend = 1'b0;
    ws_allowin = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("drain_exp", 32'(exp_q.size()), 32'd0);
    chk("drain_sram", 32'(sram_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
